// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants, state/decode types and instruction field helpers
// for the ctrl_unit sequencer.
// Optional feature macro: CTRL_BRANCH_EN (enables the JZ conditional jump).
package ctrl_pkg;
  localparam int PC_W = 8;
  localparam int IW   = 16;
  localparam int NREG = 5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b111;
  localparam logic       MUX_IMM  = 1'b1;
  localparam logic       MUX_RF   = 1'b0;

  // field-slice positions
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int AOP_LSB = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LD_IMM, S_RD_B,
    S_LAT_B, S_RD_A, S_EXEC, S_WB, S_HALT
  } state_t;

  // instruction class after legality filtering; illegal instructions become K_NOP
  typedef enum logic [2:0] {K_NOP, K_LDI, K_ALU, K_JMP, K_JZ, K_HALT} kind_t;

  typedef struct packed {
    kind_t kind;
    logic  legal;
  } dec_t;

  function automatic logic [3:0] f_op(input logic [IW-1:0] w);
    return w[OP_LSB +: 4];
  endfunction
  function automatic logic [3:0] f_rd(input logic [IW-1:0] w);
    return w[RD_LSB +: 4];
  endfunction
  function automatic logic [3:0] f_rs(input logic [IW-1:0] w);
    return w[RS_LSB +: 4];
  endfunction
  function automatic logic [2:0] f_aop(input logic [IW-1:0] w);
    return w[AOP_LSB +: 3];
  endfunction
  function automatic logic [7:0] f_imm(input logic [IW-1:0] w);
    return w[IMM_LSB +: 8];
  endfunction
endpackage

// File: rtl/ctrl_if.sv
// ctrl_if: instruction-ROM and datapath control bus of ctrl_unit.
//   pc/instr        : ROM address out, ROM data back (one cycle later)
//   alu_zero        : datapath status in
//   r_wf, en_*      : register-file / operand / ALU / immediate controls
//   imm, sel_*      : immediate value, ALU op, register index, op1 source
// master = sequencer side, slave = ROM/datapath side.
interface ctrl_if;
  import ctrl_pkg::*;
  logic [PC_W-1:0] pc;
  logic [IW-1:0]   instr;
  logic            alu_zero;
  logic            r_wf;
  logic            en_rf;
  logic            en_reg;
  logic            en_alu;
  logic            en_imm;
  logic [7:0]      imm;
  logic [2:0]      sel_alu;
  logic [3:0]      sel_rf;
  logic            sel_mux;

  modport master (
    output pc, r_wf, en_rf, en_reg, en_alu, en_imm, imm, sel_alu, sel_rf, sel_mux,
    input  instr, alu_zero
  );
  modport slave (
    input  pc, r_wf, en_rf, en_reg, en_alu, en_imm, imm, sel_alu, sel_rf, sel_mux,
    output instr, alu_zero
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction classifier.
//   ir  in  : instruction word
//   dec out : {class, legal}; bad opcode or register index >= NREG_P gives
//             legal=0 and class K_NOP.
// CTRL_BRANCH_EN: when undefined, opcode 4 (JZ) is illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int NREG_P = NREG
) (
  input  logic [IW-1:0] ir,
  output dec_t          dec
);
  localparam logic [3:0] LIM = 4'(NREG_P);

  always_comb begin
    dec.kind  = K_NOP;
    dec.legal = 1'b1;
    case (f_op(ir))
      OP_NOP:  ;
      OP_LDI:  if (f_rd(ir) < LIM) dec.kind = K_LDI; else dec.legal = 1'b0;
      OP_ALU:  if (f_rd(ir) < LIM && f_rs(ir) < LIM) dec.kind = K_ALU;
               else dec.legal = 1'b0;
      OP_JMP:  dec.kind = K_JMP;
`ifdef CTRL_BRANCH_EN
      OP_JZ:   dec.kind = K_JZ;
`else
      OP_JZ:   dec.legal = 1'b0;
`endif
      OP_HALT: dec.kind = K_HALT;
      default: dec.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: fetch/decode sequencer driving the datapath, one micro-op per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : 1-cycle pulse, starts at pc=0 from IDLE (ignored otherwise)
//   bus      : ctrl_if master (ROM address/data, datapath controls, alu_zero)
//   busy     : state is neither IDLE nor HALT
//   halted   : in HALT
//   illegal  : sticky bad-opcode / bad-register flag, cleared by rst
// CTRL_BRANCH_EN: enables JZ (jump when alu_zero, as left by the last EXEC).
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int NREG_P = NREG
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  ctrl_if.master   bus,
  output logic     busy,
  output logic     halted,
  output logic     illegal
);
  state_t          state, nstate;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [IW-1:0]   ir;
  dec_t            dec;
  // last driven select values, replayed when no state drives them
  logic [3:0]      sel_rf_q;
  logic [7:0]      imm_q;
  logic [2:0]      sel_alu_q;
  logic            sel_mux_q;
  logic            unused_ir3;

  assign unused_ir3 = ir[3];

  // classify the word arriving from ROM during DECODE (IR is loaded on that edge)
  ctrl_decode #(.NREG_P(NREG_P)) u_dec (.ir(bus.instr), .dec(dec));

  always_comb begin
    pc_nxt = pc_q + PC_W'(1);
    if (dec.kind == K_JMP) pc_nxt = PC_W'(f_imm(bus.instr));
`ifdef CTRL_BRANCH_EN
    if (dec.kind == K_JZ && bus.alu_zero) pc_nxt = PC_W'(f_imm(bus.instr));
`endif
  end

`ifndef CTRL_BRANCH_EN
  logic unused_az;
  assign unused_az = bus.alu_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      ir        <= '0;
      illegal   <= 1'b0;
      sel_rf_q  <= '0;
      imm_q     <= '0;
      sel_alu_q <= '0;
      sel_mux_q <= 1'b0;
    end else begin
      state     <= nstate;
      sel_rf_q  <= bus.sel_rf;
      imm_q     <= bus.imm;
      sel_alu_q <= bus.sel_alu;
      sel_mux_q <= bus.sel_mux;
      if (state == S_DECODE) begin
        ir   <= bus.instr;
        pc_q <= pc_nxt;
        if (!dec.legal) illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    nstate      = state;
    bus.r_wf    = 1'b0;
    bus.en_rf   = 1'b0;
    bus.en_reg  = 1'b0;
    bus.en_alu  = 1'b0;
    bus.en_imm  = 1'b0;
    bus.sel_rf  = sel_rf_q;
    bus.imm     = imm_q;
    bus.sel_alu = sel_alu_q;
    bus.sel_mux = sel_mux_q;
    case (state)
      S_IDLE:   if (start) nstate = S_FETCH;
      S_FETCH:  nstate = S_DECODE;
      S_DECODE: begin
        case (dec.kind)
          K_LDI:   nstate = S_LD_IMM;
          K_ALU:   nstate = S_RD_B;
          K_HALT:  nstate = S_HALT;
          default: nstate = S_FETCH;
        endcase
      end
      S_LD_IMM: begin
        bus.en_imm = 1'b1;
        bus.imm    = f_imm(ir);
        nstate     = S_EXEC;
      end
      S_RD_B: begin
        bus.en_rf  = 1'b1;
        bus.sel_rf = f_rs(ir);
        nstate     = S_LAT_B;
      end
      S_LAT_B: begin
        bus.en_reg = 1'b1;
        nstate     = S_RD_A;
      end
      S_RD_A: begin
        bus.en_rf   = 1'b1;
        bus.sel_rf  = f_rd(ir);
        bus.sel_mux = MUX_RF;
        nstate      = S_EXEC;
      end
      S_EXEC: begin
        bus.en_alu = 1'b1;
        if (f_op(ir) == OP_LDI) begin
          bus.sel_mux = MUX_IMM;
          bus.sel_alu = ALU_PASS;
        end else begin
          bus.sel_alu = f_aop(ir);
        end
        nstate = S_WB;
      end
      S_WB: begin
        bus.en_rf  = 1'b1;
        bus.r_wf   = 1'b1;
        bus.sel_rf = f_rd(ir);
        nstate     = S_FETCH;
      end
      S_HALT:   nstate = S_HALT;
      default:  nstate = S_IDLE;
    endcase
  end

  assign bus.pc = pc_q;
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);
endmodule
